// File: rtl/misc_outreg.sv
// misc_outreg: registered 2-entry output stage behind the Misc datapath.
// Captures XOUT1/XOUT2 plus their full-width sum and counts delivered results.
module misc_outreg #(
    parameter int NX = 8,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [NX-1:0] XOUT1,
    input  logic [NX-1:0] XOUT2,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [NX-1:0] OUT_X1,
    output logic [NX-1:0] OUT_X2,
    output logic [NX:0]   OUT_SUM,
    output logic [CW-1:0] XFER_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          rptr_q, rptr_d;
    logic          wptr_q, wptr_d;
    logic [NX-1:0] x1_q  [2];
    logic [NX-1:0] x1_d  [2];
    logic [NX-1:0] x2_q  [2];
    logic [NX-1:0] x2_d  [2];
    logic [NX:0]   sum_q [2];
    logic [NX:0]   sum_d [2];
    logic [CW-1:0] xfer_q, xfer_d;

    logic          push;
    logic          pop;
    logic          head;

    // Handshake qualifiers; ready comes only from registered state.
    always_comb begin
        IN_READY  = (state_q != FULL) & ~RST;
        OUT_VALID = (state_q != EMPTY);
        push      = IN_VALID & IN_READY;
        pop       = OUT_VALID & OUT_READY;
    end

    // Next-state for fill state, pointers, entries and transfer count.
    always_comb begin
        state_d = state_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        xfer_d  = xfer_q;
        for (int i = 0; i < 2; i++) begin
            x1_d[i]  = x1_q[i];
            x2_d[i]  = x2_q[i];
            sum_d[i] = sum_q[i];
        end
        if (push) begin
            x1_d[wptr_q]  = XOUT1;
            x2_d[wptr_q]  = XOUT2;
            sum_d[wptr_q] = {1'b0, XOUT1} + {1'b0, XOUT2};
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
            xfer_d = xfer_q + CW'(1);
        end
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // When empty, the slot behind the read pointer is the last popped entry.
    always_comb begin
        head     = (state_q == EMPTY) ? ~rptr_q : rptr_q;
        OUT_X1   = x1_q[head];
        OUT_X2   = x2_q[head];
        OUT_SUM  = sum_q[head];
        XFER_CNT = xfer_q;
    end

    // State registers; reset discards buffered entries immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            xfer_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                x1_q[i]  <= '0;
                x2_q[i]  <= '0;
                sum_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            xfer_q  <= xfer_d;
            for (int i = 0; i < 2; i++) begin
                x1_q[i]  <= x1_d[i];
                x2_q[i]  <= x2_d[i];
                sum_q[i] <= sum_d[i];
            end
        end
    end

endmodule

// File: tb/tb_misc_outreg.sv
// tb_misc_outreg: directed checks of misc_outreg handshake, data and counter.
// A second instance with a 4-bit counter shares the stimulus for wrap checks.
module tb_misc_outreg;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] xout1;
    logic [7:0] xout2;

    logic        in_ready, out_valid;
    logic [7:0]  out_x1, out_x2;
    logic [8:0]  out_sum;
    logic [15:0] xfer_cnt;

    logic        w_in_ready, w_out_valid;
    logic [7:0]  w_out_x1, w_out_x2;
    logic [8:0]  w_out_sum;
    logic [3:0]  w_xfer_cnt;

    int total;
    int passed;

    misc_outreg #(.NX(8), .CW(16)) u_dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .XOUT1(xout1), .XOUT2(xout2),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_X1(out_x1), .OUT_X2(out_x2), .OUT_SUM(out_sum),
        .XFER_CNT(xfer_cnt)
    );

    misc_outreg #(.NX(8), .CW(4)) u_wrap (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(w_in_ready),
        .XOUT1(xout1), .XOUT2(xout2),
        .OUT_VALID(w_out_valid), .OUT_READY(out_ready),
        .OUT_X1(w_out_x1), .OUT_X2(w_out_x2), .OUT_SUM(w_out_sum),
        .XFER_CNT(w_xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        xout1 = 8'hAA;
        xout2 = 8'h55;
        tick();
        tick();
        total++;
        if ({out_valid, in_ready, xfer_cnt, out_x1, out_x2, out_sum} !==
            {1'b0, 1'b0, 16'd0, 8'd0, 8'd0, 9'd0})
            $display("FAIL reset_state: got v=%0b r=%0b cnt=%0d x1=%h x2=%h s=%h want all zero",
                     out_valid, in_ready, xfer_cnt, out_x1, out_x2, out_sum);
        else passed++;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_single_push();
        xout1 = 8'h10;
        xout2 = 8'h20;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_x1, out_x2, out_sum} !== {1'b1, 8'h10, 8'h20, 9'h030})
            $display("FAIL single_head: got v=%0b %h %h %h want 1 10 20 030",
                     out_valid, out_x1, out_x2, out_sum);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd1)
            $display("FAIL single_pop: got v=%0b cnt=%0d want 0 1", out_valid, xfer_cnt);
        else passed++;
        total++;
        if (out_x1 !== 8'h10 || out_sum !== 9'h030)
            $display("FAIL hold_last: got x1=%h sum=%h want 10 030", out_x1, out_sum);
        else passed++;
    endtask

    task automatic test_sum_carry();
        xout1 = 8'hFF;
        xout2 = 8'h01;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_sum !== 9'h100)
            $display("FAIL sum_carry: got v=%0b sum=%h want 1 100", out_valid, out_sum);
        else passed++;
        tick();
        total++;
        if (xfer_cnt !== 16'd2)
            $display("FAIL sum_carry_cnt: got %0d want 2", xfer_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1;
        xout1 = 8'd1; xout2 = 8'd2;
        tick();
        xout1 = 8'd3; xout2 = 8'd4;
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_x1 !== 8'd1)
            $display("FAIL bp_full: got ready=%0b v=%0b x1=%0d want 0 1 1",
                     in_ready, out_valid, out_x1);
        else passed++;
        xout1 = 8'd5; xout2 = 8'd6;
        tick();
        total++;
        if (out_x1 !== 8'd1 || out_x2 !== 8'd2 || in_ready !== 1'b0)
            $display("FAIL bp_stable: got %0d %0d ready=%0b want 1 2 0",
                     out_x1, out_x2, in_ready);
        else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_x1 !== 8'd3 || out_x2 !== 8'd4 || in_ready !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL bp_second: got %0d %0d ready=%0b v=%0b want 3 4 1 1",
                     out_x1, out_x2, in_ready, out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd4)
            $display("FAIL bp_drain: got v=%0b cnt=%0d want 0 4 (5,6 dropped)",
                     out_valid, xfer_cnt);
        else passed++;
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        in_valid = 1'b1;
        xout1 = 8'd7; xout2 = 8'd8;
        tick();
        xout1 = 8'd9; xout2 = 8'd10;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready, out_x1, out_x2, out_sum} !==
            {1'b1, 1'b1, 8'd9, 8'd10, 9'd19} || xfer_cnt !== 16'd5)
            $display("FAIL push_pop: got v=%0b r=%0b %0d %0d %0d cnt=%0d want 1 1 9 10 19 5",
                     out_valid, in_ready, out_x1, out_x2, out_sum, xfer_cnt);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd6)
            $display("FAIL push_pop_drain: got v=%0b cnt=%0d want 0 6", out_valid, xfer_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        pulse_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            xout1 = 8'(i);
            xout2 = 8'(2 * i);
            tick();
            if (out_valid !== 1'b1 || out_x1 !== 8'(i) || out_x2 !== 8'(2 * i) ||
                out_sum !== 9'(i % 256 + (2 * i) % 256) || in_ready !== 1'b1)
                bad++;
            if (i == 17) begin
                total++;
                if (w_xfer_cnt !== 4'd1 || xfer_cnt !== 16'd17)
                    $display("FAIL wrap17: got cw4=%0d cnt=%0d want 1 17",
                             w_xfer_cnt, xfer_cnt);
                else passed++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (bad != 0)
            $display("FAIL stream_data: got %0d bad cycles want 0", bad);
        else passed++;
        tick();
        total++;
        if (xfer_cnt !== 16'd300 || w_xfer_cnt !== 4'd12 || out_valid !== 1'b0)
            $display("FAIL stream_count: got cnt=%0d cw4=%0d v=%0b want 300 12 0",
                     xfer_cnt, w_xfer_cnt, out_valid);
        else passed++;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        xout1 = 8'h31; xout2 = 8'h32;
        tick();
        xout1 = 8'h41; xout2 = 8'h42;
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || xfer_cnt !== 16'd300)
            $display("FAIL ar_full: got r=%0b v=%0b cnt=%0d want 0 1 300",
                     in_ready, out_valid, xfer_cnt);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, xfer_cnt, w_xfer_cnt, out_x1, out_sum} !==
            {1'b0, 1'b0, 16'd0, 4'd0, 8'd0, 9'd0})
            $display("FAIL async_reset: got v=%0b r=%0b cnt=%0d cw4=%0d x1=%h s=%h want 0",
                     out_valid, in_ready, xfer_cnt, w_xfer_cnt, out_x1, out_sum);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL ar_release: got r=%0b v=%0b want 1 0", in_ready, out_valid);
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        xout1 = '0;
        xout2 = '0;
        #2;
        test_reset();
        test_single_push();
        test_sum_carry();
        test_backpressure();
        test_push_pop();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
